imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a byte stream of little-endian
// 32-bit words followed by an XOR checksum byte, writes them to IMEM and holds the CPU until done.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [CW-1:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   count, count_d;
    logic [CW-1:0]   word_idx, word_idx_d;
    logic [1:0]      byte_cnt, byte_cnt_d;
    logic [7:0]      csum, csum_d;
    logic [31:0]     word, word_d;
    logic            err_d;
    logic            byte_ready_d, imem_we_d, cpu_hold_d, busy_d, done_d;
    logic [31:0]     imem_addr_d, imem_wdata_d;
    logic            xfer;
    logic            last_word;
    logic            accept_start;

    assign xfer         = byte_valid & byte_ready;
    assign last_word    = (word_idx + CW'(1)) == count;
    assign accept_start = start & ((state == IDLE) | (state == DONE));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (word_count > CAPACITY) begin
                        state_d = DONE;
                    end else if (word_count == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV:    if (xfer && byte_cnt == 2'd3) state_d = WRITE;
            WRITE:   state_d = last_word ? CHECK : RECV;
            CHECK:   if (xfer) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and next output values, registered below
    always_comb begin
        count_d    = count;
        word_idx_d = word_idx;
        byte_cnt_d = byte_cnt;
        csum_d     = csum;
        word_d     = word;
        err_d      = err;

        if (accept_start) begin
            count_d    = word_count;
            word_idx_d = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
            err_d      = word_count > CAPACITY;
        end

        unique case (state)
            RECV: begin
                if (xfer) begin
                    word_d[{byte_cnt, 3'b000} +: 8] = byte_in;
                    csum_d     = csum ^ byte_in;
                    byte_cnt_d = byte_cnt + 2'd1;
                end
            end
            WRITE:   word_idx_d = word_idx + CW'(1);
            CHECK:   if (xfer) err_d = (byte_in != csum);
            default: ;
        endcase

        byte_ready_d = (state_d == RECV) || (state_d == CHECK);
        busy_d       = (state_d == RECV) || (state_d == WRITE) || (state_d == CHECK);
        done_d       = (state_d == DONE);
        cpu_hold_d   = !((state_d == DONE) && !err_d);
        imem_we_d    = (state_d == WRITE);

        // Address/data only move when a write is issued, so they stay stable otherwise
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
        if (state_d == WRITE) begin
            imem_addr_d  = 32'({word_idx_d, 2'b00});
            imem_wdata_d = word_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            csum       <= '0;
            word       <= '0;
            err        <= 1'b0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            count      <= count_d;
            word_idx   <= word_idx_d;
            byte_cnt   <= byte_cnt_d;
            csum       <= csum_d;
            word       <= word_d;
            err        <= err_d;
            byte_ready <= byte_ready_d;
            imem_we    <= imem_we_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
            cpu_hold   <= cpu_hold_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, checksum-error, empty, oversize,
// stalled-stream and mid-load-reset loads against hand-computed expectations.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stream[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe seen mid-cycle
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 100) begin
            tick();
            n++;
        end
        if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        else tick();
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic [ADDR_W:0] cnt);
        wr_addr.delete();
        wr_data.delete();
        word_count = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_stream_2w();
        stream = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, wr_addr[0], 32'h0);
            check({tag, "_d0"}, wr_data[0], 32'h0000_0513);
            check({tag, "_a1"}, wr_addr[1], 32'h4);
            check({tag, "_d1"}, wr_data[1], 32'h0010_0593);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"},    32'(imem_we),    32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_err"},   32'(err),        32'd0);
        check({tag, "_hold"},  32'(cpu_hold),   32'd1);
        check({tag, "_addr"},  imem_addr,       32'd0);
        check({tag, "_wdata"}, imem_wdata,      32'd0);
    endtask

    initial begin
        logic [7:0]  cs;
        logic [31:0] exp_w;
        int          nw;

        reset = 1'b0; start = 1'b0; word_count = '0;
        byte_in = '0; byte_valid = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Normal two-word load, with write-latency checks on the first word
        set_stream_2w();
        do_start(9'd2);
        check("n_busy",  32'(busy),       32'd1);
        check("n_ready", 32'(byte_ready), 32'd1);
        check("n_hold",  32'(cpu_hold),   32'd1);
        for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
        check("n_we_lat", 32'(imem_we), 32'd1);
        check("n_addr0",  imem_addr,    32'h0);
        check("n_data0",  imem_wdata,   32'h0000_0513);
        check("n_rdy_wr", 32'(byte_ready), 32'd0);
        for (int i = 4; i < 8; i++) send_byte(stream[i], 0);
        send_byte(8'h90, 0);
        check("n_done", 32'(done),     32'd1);
        check("n_err",  32'(err),      32'd0);
        check("n_hold2",32'(cpu_hold), 32'd0);
        check("n_busy2",32'(busy),     32'd0);
        check_two_writes("n");

        // Restart from DONE
        do_start(9'd2);
        check("rs_hold", 32'(cpu_hold), 32'd1);
        check("rs_done", 32'(done),     32'd0);
        foreach (stream[i]) send_byte(stream[i], 0);
        send_byte(8'h90, 0);
        check("rs_done2", 32'(done), 32'd1);
        check("rs_err",   32'(err),  32'd0);
        check_two_writes("rs");

        // Checksum error
        do_start(9'd2);
        foreach (stream[i]) send_byte(stream[i], 0);
        send_byte(8'h91, 0);
        check("ce_done", 32'(done),     32'd1);
        check("ce_err",  32'(err),      32'd1);
        check("ce_hold", 32'(cpu_hold), 32'd1);
        check_two_writes("ce");

        // Empty load
        do_start(9'd0);
        check("e_ready", 32'(byte_ready), 32'd1);
        check("e_busy",  32'(busy),       32'd1);
        send_byte(8'h00, 0);
        check("e_done", 32'(done), 32'd1);
        check("e_err",  32'(err),  32'd0);
        check("e_hold", 32'(cpu_hold), 32'd0);
        check("e_nwr",  32'(wr_addr.size()), 32'd0);

        // Oversize load, with a byte offered the whole time
        byte_in = 8'hAA; byte_valid = 1'b1;
        do_start(9'd257);
        check("o_done",  32'(done),       32'd1);
        check("o_err",   32'(err),        32'd1);
        check("o_ready", 32'(byte_ready), 32'd0);
        check("o_busy",  32'(busy),       32'd0);
        check("o_hold",  32'(cpu_hold),   32'd1);
        repeat (3) tick();
        byte_valid = 1'b0;
        check("o_nwr", 32'(wr_addr.size()), 32'd0);

        // Four-word load with random stalls and an ignored start mid-load
        stream = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00,
                   8'h33, 8'h06, 8'hb5, 8'h00, 8'h67, 8'h80, 8'h00, 8'h00};
        cs = '0;
        foreach (stream[i]) cs = cs ^ stream[i];
        do_start(9'd4);
        foreach (stream[i]) begin
            send_byte(stream[i], int'($urandom_range(0, 3)));
            if (i == 1) begin
                word_count = 9'd1;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        send_byte(cs, 2);
        check("g_done", 32'(done), 32'd1);
        check("g_err",  32'(err),  32'd0);
        nw = wr_addr.size();
        check("g_nwr", 32'(nw), 32'd4);
        for (int w = 0; w < 4 && w < nw; w++) begin
            exp_w = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
            check($sformatf("g_a%0d", w), wr_addr[w], 32'(4 * w));
            check($sformatf("g_d%0d", w), wr_data[w], exp_w);
        end

        // Reset after byte 6 of the normal load
        set_stream_2w();
        do_start(9'd2);
        for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
        reset = 1'b0;
        #1;
        check_reset_outputs("mr");
        wr_addr.delete();
        wr_data.delete();
        byte_in = 8'h00; byte_valid = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (6) tick();
        byte_valid = 1'b0;
        check("mr_nwr",  32'(wr_addr.size()), 32'd0);
        check("mr_busy", 32'(busy),       32'd0);
        check("mr_rdy",  32'(byte_ready), 32'd0);
        check("mr_hold", 32'(cpu_hold),   32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
